digit_overlay_renderer: RTL and testbench

Pixel-stream renderer for a multi-digit decimal number drawn over the map field, such as the level number or height counter. A binary value is loaded and converted to BCD by a multi-cycle double-dabble engine. The displayed digits change only on a frame boundary, so no frame ever shows a half-updated number. Each pixel is classified against up to NUM_DIGITS scaled 10x10 glyphs through a 2-stage pipeline; leading-zero blanking and blinking are optional. The block sits between the pixel-coordinate generator and the VGA colour mux.

---
 rtl/digit_overlay_renderer.sv | 242 ++++++++++++++++++++++++
 tb/tb_digit_overlay_renderer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_overlay_renderer.sv
// Multi-digit decimal overlay: a double-dabble BCD engine feeds display registers
// that change only on frame_tick, and a 2-stage pixel pipeline renders 10x10 glyphs.
module digit_overlay_renderer #(
    parameter int PIXEL_WIDTH  = 12,
    parameter int PHY_WIDTH    = 14,
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_WIDTH  = 14,
    parameter int SCALE_SHIFT  = 3,
    parameter int ORIGIN_X     = 130,
    parameter int ORIGIN_Y     = 160,
    parameter int DIGIT_PITCH  = 120,
    parameter logic [PIXEL_WIDTH-1:0] BG_COLOR  = 12'hA21,
    parameter logic [PIXEL_WIDTH-1:0] FG_COLOR  = 12'hFFF,
    parameter logic [PIXEL_WIDTH-1:0] OFF_COLOR = 12'hFFF,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   value_load,
    input  logic                   frame_tick,
    input  logic                   blink_en,
    input  logic                   lz_blank,
    input  logic                   pix_valid_in,
    input  logic [PHY_WIDTH-1:0]   map_x,
    input  logic [PHY_WIDTH-1:0]   map_y,
    input  logic                   map_on,
    output logic [PIXEL_WIDTH-1:0] rgb,
    output logic                   rgb_valid,
    output logic                   busy,
    output logic                   overflow
);
    localparam int          BCD_W = 4 * NUM_DIGITS;
    localparam int          CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam int          BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int          IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [31:0] CELL  = 32'(10 << SCALE_SHIFT);
    localparam int unsigned SAT_LIMIT = (NUM_DIGITS == 1) ? 10 : (NUM_DIGITS == 2) ? 100 :
                                        (NUM_DIGITS == 3) ? 1000 : (NUM_DIGITS == 4) ? 10000 : 100000;

    // Row 0 in the top 10 bits; within a row bit 9 is the leftmost column. Code 10 is minus.
    localparam logic [99:0] FONT [0:10] = '{
        {10'b0011111100, 10'b0110000110, 10'b0110001110, 10'b0110010110, 10'b0110100110,
         10'b0111000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0000110000, 10'b0001110000, 10'b0011110000, 10'b0000110000, 10'b0000110000,
         10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0011111100, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000001100, 10'b0000011000,
         10'b0000110000, 10'b0001100000, 10'b0011000000, 10'b0111111110, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000111100, 10'b0000000110,
         10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0000011100, 10'b0000111100, 10'b0001101100, 10'b0011001100, 10'b0110001100,
         10'b0111111110, 10'b0000001100, 10'b0000001100, 10'b0000001100, 10'b0000000000},
        {10'b0111111110, 10'b0110000000, 10'b0110000000, 10'b0111111100, 10'b0000000110,
         10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0001111100, 10'b0011000000, 10'b0110000000, 10'b0111111100, 10'b0110000110,
         10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0011111110, 10'b0000000110, 10'b0000001100, 10'b0000011000, 10'b0000110000,
         10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0110000110,
         10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111110,
         10'b0000000110, 10'b0000000110, 10'b0000001100, 10'b0011111000, 10'b0000000000},
        {10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0111111110,
         10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000}
    };

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_WAIT_FRAME} state_t;

    state_t                         r_state, w_state_nxt;
    logic [VALUE_WIDTH-1:0]         r_bin, w_bin_nxt, r_pend_val, w_start_val;
    logic [BCD_W-1:0]               r_bcd, w_bcd_adj, w_bcd_nxt;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_sat, r_pend_vld, r_ovf, r_phase;
    logic [NUM_DIGITS-1:0][3:0]     r_disp;
    logic [BLK_W-1:0]               r_bcnt;
    logic                           w_commit, w_start;

    function automatic logic [31:0] f_x0(input int k);
        return 32'(ORIGIN_X + k * DIGIT_PITCH);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:       if (value_load) w_state_nxt = S_CONVERT;
            S_CONVERT:    if (r_cnt == CNT_W'(VALUE_WIDTH - 1)) w_state_nxt = S_WAIT_FRAME;
            S_WAIT_FRAME: if (frame_tick) w_state_nxt = (value_load || r_pend_vld) ? S_CONVERT : S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_commit    = (r_state == S_WAIT_FRAME) && frame_tick;
    assign w_start     = ((r_state == S_IDLE) && value_load) || (w_commit && (value_load || r_pend_vld));
    assign w_start_val = value_load ? value_in : r_pend_val;

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_bin[VALUE_WIDTH-1]};
        w_bin_nxt = {r_bin[VALUE_WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
            r_disp     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start) begin
                r_bin <= w_start_val;
                r_bcd <= '0;
                r_cnt <= '0;
                r_sat <= 32'(w_start_val) >= SAT_LIMIT;
            end else if (r_state == S_CONVERT) begin
                r_bin <= w_bin_nxt;
                r_bcd <= w_bcd_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
            // A load in the commit cycle becomes the next conversion directly.
            if (w_commit) begin
                r_pend_vld <= 1'b0;
            end else if (value_load && r_state != S_IDLE) begin
                r_pend_vld <= 1'b1;
                r_pend_val <= value_in;
            end
            if (w_commit) begin
                r_ovf <= r_sat;
                for (int k = 0; k < NUM_DIGITS; k++)
                    r_disp[k] <= r_sat ? 4'd9 : r_bcd[4*(NUM_DIGITS-1-k) +: 4];
            end
        end
    end

    assign overflow = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (frame_tick) begin
            if (r_bcnt == BLK_W'(BLINK_FRAMES - 1)) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    // Stage 1: hit test, glyph address and blanking against the current display.
    logic [31:0]           w_x, w_y;
    logic                  w_hit, w_yin, w_allz, w_blank;
    logic [IDX_W-1:0]      w_idx;
    logic [3:0]            w_row, w_col, w_code;
    logic [NUM_DIGITS-1:0] w_lz;

    assign w_x   = {{(32-PHY_WIDTH){1'b0}}, map_x};
    assign w_y   = {{(32-PHY_WIDTH){1'b0}}, map_y};
    assign w_yin = (w_y >= 32'(ORIGIN_Y)) && (w_y < 32'(ORIGIN_Y) + CELL);
    assign w_row = 4'((w_y - 32'(ORIGIN_Y)) >> SCALE_SHIFT);

    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        w_col = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_x >= f_x0(k) && w_x < f_x0(k) + CELL) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(k);
                w_col = 4'((w_x - f_x0(k)) >> SCALE_SHIFT);
            end
        end
    end

    always_comb begin
        w_lz   = '0;
        w_allz = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_allz  = w_allz & (r_disp[k] == 4'd0);
            w_lz[k] = lz_blank & w_allz & (k < NUM_DIGITS - 1);
        end
    end

    assign w_blank = (blink_en & r_phase) | w_lz[w_idx];
    assign w_code  = r_disp[w_idx];

    logic       r1_hit, r1_blank, r1_on;
    logic [3:0] r1_code, r1_row, r1_col;
    logic [1:0] r_vld_pipe;
    logic       w_fbit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_hit     <= 1'b0;
            r1_blank   <= 1'b0;
            r1_on      <= 1'b0;
            r1_code    <= '0;
            r1_row     <= '0;
            r1_col     <= '0;
            r_vld_pipe <= '0;
        end else begin
            r1_hit     <= w_hit & w_yin;
            r1_blank   <= w_blank;
            r1_on      <= map_on;
            r1_code    <= w_code;
            r1_row     <= w_row;
            r1_col     <= w_col;
            r_vld_pipe <= {r_vld_pipe[0], pix_valid_in};
        end
    end

    // Stage 2: font lookup and colour; rgb holds across invalid pixels.
    always_comb begin
        w_fbit = 1'b0;
        if (r1_hit) w_fbit = FONT[r1_code][7'(99 - 10 * r1_row - r1_col)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (r_vld_pipe[0]) begin
            if (!r1_on)                        rgb <= OFF_COLOR;
            else if (w_fbit && !r1_blank)      rgb <= FG_COLOR;
            else                               rgb <= BG_COLOR;
        end
    end

    assign rgb_valid = r_vld_pipe[1];
endmodule

// File: tb/tb_digit_overlay_renderer.sv
// Randomised and directed bench for digit_overlay_renderer against a timestamp-based
// behavioural model that renders digits from the displayed integer with / and %.
module tb_digit_overlay_renderer;
    localparam int ND = 4, VW = 14, BF = 2;
    localparam logic [11:0] BG = 12'hA21, FG = 12'hFFF, OFF = 12'hFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [13:0] value_in = '0, map_x = '0, map_y = '0;
    logic        value_load = 0, frame_tick = 0, blink_en = 0, lz_blank = 0, pix_valid_in = 0, map_on = 0;
    logic [11:0] rgb;
    logic        rgb_valid, busy, overflow;

    always #5 clk = ~clk;

    digit_overlay_renderer #(.NUM_DIGITS(ND), .VALUE_WIDTH(VW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_load(value_load),
        .frame_tick(frame_tick), .blink_en(blink_en), .lz_blank(lz_blank),
        .pix_valid_in(pix_valid_in), .map_x(map_x), .map_y(map_y), .map_on(map_on),
        .rgb(rgb), .rgb_valid(rgb_valid), .busy(busy), .overflow(overflow));

    logic [99:0] FONT [0:10] = '{
        {10'b0011111100, 10'b0110000110, 10'b0110001110, 10'b0110010110, 10'b0110100110,
         10'b0111000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0000110000, 10'b0001110000, 10'b0011110000, 10'b0000110000, 10'b0000110000,
         10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0011111100, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000001100, 10'b0000011000,
         10'b0000110000, 10'b0001100000, 10'b0011000000, 10'b0111111110, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000111100, 10'b0000000110,
         10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0000011100, 10'b0000111100, 10'b0001101100, 10'b0011001100, 10'b0110001100,
         10'b0111111110, 10'b0000001100, 10'b0000001100, 10'b0000001100, 10'b0000000000},
        {10'b0111111110, 10'b0110000000, 10'b0110000000, 10'b0111111100, 10'b0000000110,
         10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0001111100, 10'b0011000000, 10'b0110000000, 10'b0111111100, 10'b0110000110,
         10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0011111110, 10'b0000000110, 10'b0000001100, 10'b0000011000, 10'b0000110000,
         10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0001100000, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0110000110,
         10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000},
        {10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111110,
         10'b0000000110, 10'b0000000110, 10'b0000001100, 10'b0011111000, 10'b0000000000},
        {10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0111111110,
         10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000}
    };
    int p10 [0:3] = '{1000, 100, 10, 1};

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: shown integer, frame count, and conversion readiness as edge timestamps.
    int          m_shown, m_frames, m_cur, m_pend, m_ready, m_cyc;
    bit          m_ovf, m_busy, m_pend_v, m_s1_vld, m_rgbv;
    logic [11:0] m_s1_rgb, m_rgb;

    task automatic model_reset();
        m_shown = 0; m_frames = 0; m_cur = 0; m_pend = 0; m_ready = 0;
        m_ovf = 0; m_busy = 0; m_pend_v = 0; m_s1_vld = 0; m_rgbv = 0;
        m_s1_rgb = '0; m_rgb = '0;
    endtask

    function automatic logic [11:0] exp_color(int x, int y, bit on, bit be, bit lz);
        if (!on) return OFF;
        for (int k = 0; k < ND; k++) begin
            int x0 = 130 + 120 * k;
            if (x >= x0 && x < x0 + 80 && y >= 160 && y < 240) begin
                int  d     = (m_shown / p10[k]) % 10;
                int  row   = (y - 160) / 8;
                int  col   = (x - x0) / 8;
                bit  blank = (be && ((m_frames / BF) % 2 == 1)) ||
                             (lz && k < ND - 1 && (m_shown / p10[k]) == 0);
                return (!blank && FONT[d][99 - 10 * row - col]) ? FG : BG;
            end
        end
        return BG;
    endfunction

    task automatic model_edge();
        m_cyc++;
        if (m_s1_vld) m_rgb = m_s1_rgb;
        m_rgbv   = m_s1_vld;
        m_s1_vld = pix_valid_in;
        m_s1_rgb = exp_color(int'(map_x), int'(map_y), map_on, blink_en, lz_blank);
        if (!m_busy) begin
            if (value_load) begin
                m_cur = int'(value_in); m_busy = 1; m_ready = m_cyc + VW + 1;
            end
        end else if (frame_tick && m_cyc >= m_ready) begin
            m_ovf   = (m_cur >= 10000);
            m_shown = m_ovf ? 9999 : m_cur;
            if (value_load)    begin m_cur = int'(value_in); m_ready = m_cyc + VW + 1; end
            else if (m_pend_v) begin m_cur = m_pend;         m_ready = m_cyc + VW + 1; end
            else               m_busy = 0;
            m_pend_v = 0;
        end else if (value_load) begin
            m_pend = int'(value_in); m_pend_v = 1;
        end
        if (frame_tick) m_frames++;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        chk("busy", busy, m_busy);
        chk("overflow", overflow, m_ovf);
        chk("rgb_valid", rgb_valid, m_rgbv);
        chk("rgb", rgb, m_rgb);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int v);
        value_load = 1; value_in = 14'(v);
        step();
        value_load = 0;
    endtask

    task automatic tick();
        frame_tick = 1;
        step();
        frame_tick = 0;
    endtask

    // Sweep every glyph cell plus a one-cell border around each digit.
    task automatic scan();
        for (int k = 0; k < ND; k++)
            for (int r = -1; r <= 10; r++)
                for (int c = -1; c <= 10; c++) begin
                    pix_valid_in = 1; map_on = 1;
                    map_x = 14'(130 + 120 * k + 8 * c + $urandom_range(7));
                    map_y = 14'(160 + 8 * r + $urandom_range(7));
                    step();
                end
        pix_valid_in = 0;
        run(2);
    endtask

    initial begin
        model_reset();
        m_cyc = 0;
        run(2);
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_busy", busy, 1'b0);
        rst_n = 1;

        // First pixel: digit 0 row 0 col 0 of glyph 0 is clear.
        pix_valid_in = 1; map_on = 1; map_x = 14'd135; map_y = 14'd165;
        step();
        pix_valid_in = 0;
        step();
        chk("pix0_rgb", rgb, BG);
        chk("pix0_valid", rgb_valid, 1'b1);

        load(1234);
        scan();
        tick();
        chk("busy_after_1234", busy, 1'b0);
        scan();

        lz_blank = 1;
        load(7);
        run(16);
        chk("busy_before_tick", busy, 1'b1);
        tick();
        scan();

        load(12000);
        run(16);
        tick();
        chk("ovf_set", overflow, 1'b1);
        scan();
        load(5);
        run(16);
        tick();
        chk("ovf_clear", overflow, 1'b0);
        lz_blank = 0;

        load(11);
        run(2);
        load(22);
        run(3);
        load(33);
        run(12);
        tick();
        scan();
        run(4);
        tick();
        scan();

        blink_en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            scan();
        end
        blink_en = 0;

        // Mid-conversion reset discards everything.
        load(4321);
        run(5);
        rst_n = 0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_rgbv", rgb_valid, 1'b0);
        model_reset();
        step();
        rst_n = 1;
        run(20);
        tick();
        scan();

        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(49) == 0);
            value_load = ($urandom_range(39) == 0);
            value_in   = $urandom_range(1) ? 14'($urandom_range(120)) : 14'($urandom_range(16383));
            if ($urandom_range(199) == 0) blink_en = ~blink_en;
            if ($urandom_range(199) == 0) lz_blank = ~lz_blank;
            map_x        = 14'($urandom_range(660, 100));
            map_y        = 14'($urandom_range(260, 140));
            map_on       = ($urandom_range(9) != 0);
            pix_valid_in = ($urandom_range(19) > 2);
            step();
        end
        value_load = 0; frame_tick = 0; pix_valid_in = 0;
        run(3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
